// File: rtl/lsu_rmw.sv
// Handshaked load/store unit: sign/zero-extended loads, full-width stores, sub-word stores by read-modify-write.
// Optional misalignment checker enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_rmw #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_re,
  output logic              Bus_we,
  output logic [DATA_W-1:0] Bus_wdata,
  input  logic [DATA_W-1:0] Bus_rdata,
  input  logic              Bus_rvalid
);

  localparam int unsigned LANE_BITS = (DATA_W == 64) ? 3 : 2;
  localparam int unsigned SH_W      = LANE_BITS + 3;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [LANE_BITS-1:0]  r_off;
  logic [DATA_W-1:0]     r_wdata;
  logic [ADDR_W-1:0]     r_bus_addr;
  logic [DATA_W-1:0]     r_bus_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_bus_re;
  logic                  r_bus_we;
  logic                  r_resp_valid;
  logic                  r_resp_err;

  logic [1:0]            w_eff_size;
  logic [LANE_BITS-1:0]  w_size_mask;
  logic [LANE_BITS-1:0]  w_off;
  logic                  w_full;
  logic                  w_err;
  logic                  w_accept;
  logic [SH_W-1:0]       w_shamt;
  logic [DATA_W-1:0]     w_lane_mask;
  logic [DATA_W-1:0]     w_rd_shift;
  logic                  w_sign;
  logic [DATA_W-1:0]     w_load_ext;
  logic [DATA_W-1:0]     w_merge;

  // Request decode: dword collapses to word on a 32-bit bus
  always_comb begin
    w_eff_size = req_size;
    if (DATA_W == 32 && req_size == 2'd3) w_eff_size = 2'd2;
    case (w_eff_size)
      2'd0:    w_size_mask = '0;
      2'd1:    w_size_mask = LANE_BITS'(1);
      2'd2:    w_size_mask = LANE_BITS'(3);
      default: w_size_mask = LANE_BITS'(7);
    endcase
  end

  assign w_off    = req_addr[LANE_BITS-1:0] & ~w_size_mask;
  assign w_full   = (w_eff_size == 2'(LANE_BITS));
  assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_CHK_EN
  assign w_err = |(req_addr[LANE_BITS-1:0] & w_size_mask);
`else
  assign w_err = 1'b0;
`endif

  // Lane extraction/extension for loads and lane merge for sub-word stores
  assign w_shamt = {r_off, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_lane_mask = DATA_W'(8'hFF);
      2'd1:    w_lane_mask = DATA_W'(16'hFFFF);
      2'd2:    w_lane_mask = DATA_W'(32'hFFFF_FFFF);
      default: w_lane_mask = '1;
    endcase
  end

  assign w_rd_shift = Bus_rdata >> w_shamt;

  always_comb begin
    case (r_size)
      2'd0:    w_sign = w_rd_shift[7];
      2'd1:    w_sign = w_rd_shift[15];
      2'd2:    w_sign = w_rd_shift[31];
      default: w_sign = w_rd_shift[DATA_W-1];
    endcase
  end

  assign w_load_ext = (w_rd_shift & w_lane_mask) |
                      ((w_sign && !r_unsigned) ? ~w_lane_mask : '0);
  assign w_merge    = (Bus_rdata & ~(w_lane_mask << w_shamt)) |
                      ((r_wdata & w_lane_mask) << w_shamt);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_err)               w_next = RESP;
          else if (req_we && w_full) w_next = WR;
          else                     w_next = RD;
        end
      end
      RD:      if (Bus_rvalid) w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered strobes follow the next state so they line up with it cycle for cycle
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_we         <= 1'b0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_rdata      <= '0;
      r_bus_re     <= 1'b0;
      r_bus_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_bus_re     <= (w_next == RD);
      r_bus_we     <= (w_next == WR);
      r_resp_valid <= (w_next == RESP);
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= w_eff_size;
        r_unsigned <= req_unsigned;
        r_off      <= w_off;
        r_wdata    <= req_wdata;
        r_bus_addr <= {req_addr[ADDR_W-1:LANE_BITS], LANE_BITS'(0)};
        r_resp_err <= w_err;
        r_rdata    <= '0;
        if (req_we && w_full) r_bus_wdata <= req_wdata;
      end else if (r_state == RD && Bus_rvalid) begin
        if (r_we) r_bus_wdata <= w_merge;
        else      r_rdata     <= w_load_ext;
      end else if (r_state == RESP) begin
        r_resp_err <= 1'b0;
        r_rdata    <= '0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_resp_err;
  assign Bus_addr   = r_bus_addr;
  assign Bus_re     = r_bus_re;
  assign Bus_we     = r_bus_we;
  assign Bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: 32-bit and 64-bit instances, directed scenarios plus randomized traffic vs a byte-level model.
module tb_lsu_rmw;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] bus_rdata;
  logic        bus_rvalid;
  bit          sel;

  logic        rdy32, rv32_o, err32, re32, we32;
  logic [31:0] rdata32, addr32, wdata32;
  logic        rdy64, rv64_o, err64, re64, we64;
  logic [63:0] rdata64, wdata64;
  logic [31:0] addr64;
  logic        vld32, vld64;

  logic        obs_ready, obs_resp_valid, obs_err, obs_re, obs_we;
  logic [63:0] obs_rdata, obs_wdata;
  logic [31:0] obs_addr;

  int checks = 0;
  int errors = 0;

  int          ob_re_first, ob_re_cnt, ob_we_first, ob_we_cnt, ob_resp_cyc;
  logic [31:0] ob_addr;
  logic [63:0] ob_wdata, ob_rdata;
  logic        ob_err, ob_overlap, ob_ready_busy, ob_ready_after, ob_resp_after, ob_timeout;

  always #5 cpu_clk = ~cpu_clk;

  assign vld32 = req_valid & ~sel;
  assign vld64 = req_valid & sel;

  lsu_rmw #(.DATA_W(32), .ADDR_W(32)) u32 (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .req_valid(vld32), .req_ready(rdy32),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(rv32_o), .resp_rdata(rdata32), .resp_err(err32),
    .Bus_addr(addr32), .Bus_re(re32), .Bus_we(we32), .Bus_wdata(wdata32),
    .Bus_rdata(bus_rdata[31:0]), .Bus_rvalid(bus_rvalid)
  );

  lsu_rmw #(.DATA_W(64), .ADDR_W(32)) u64 (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .req_valid(vld64), .req_ready(rdy64),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv64_o), .resp_rdata(rdata64), .resp_err(err64),
    .Bus_addr(addr64), .Bus_re(re64), .Bus_we(we64), .Bus_wdata(wdata64),
    .Bus_rdata(bus_rdata), .Bus_rvalid(bus_rvalid)
  );

  assign obs_ready      = sel ? rdy64 : rdy32;
  assign obs_resp_valid = sel ? rv64_o : rv32_o;
  assign obs_err        = sel ? err64 : err32;
  assign obs_re         = sel ? re64 : re32;
  assign obs_we         = sel ? we64 : we32;
  assign obs_rdata      = sel ? rdata64 : {32'd0, rdata32};
  assign obs_wdata      = sel ? wdata64 : {32'd0, wdata32};
  assign obs_addr       = sel ? addr64 : addr32;

  // Reference model: byte-lane arithmetic on a memory word
  function automatic int eff_size(input int dw, input int sz);
    return (dw == 32 && sz == 3) ? 2 : sz;
  endfunction

  function automatic logic [63:0] m_load(input int dw, input int sz, input bit uns,
                                         input logic [31:0] addr, input logic [63:0] word);
    int nbytes = dw / 8;
    int nb = 1 << sz;
    int off = ((int'(addr) & (nbytes - 1)) / nb) * nb;
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!uns && v[8*nb-1]) for (int i = nb; i < nbytes; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] m_merge(input int dw, input int sz, input logic [31:0] addr,
                                          input logic [63:0] word, input logic [63:0] wd);
    int nbytes = dw / 8;
    int nb = 1 << sz;
    int off = ((int'(addr) & (nbytes - 1)) / nb) * nb;
    logic [63:0] v = word;
    for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  // Drives one request and records what the selected DUT does, cycle numbers relative to the accept edge
  task automatic run_txn(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] mem, input int dly, input bit hold);
    int cyc;
    bit done;
    @(negedge cpu_clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    bus_rdata = mem; bus_rvalid = 1'b0; req_valid = 1'b1;
    @(posedge cpu_clk);
    ob_re_first = -1; ob_re_cnt = 0; ob_we_first = -1; ob_we_cnt = 0; ob_resp_cyc = -1;
    ob_addr = '0; ob_wdata = '0; ob_rdata = '0; ob_err = 1'b0; ob_overlap = 1'b0;
    ob_ready_busy = 1'b0; ob_timeout = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge cpu_clk);
      cyc++;
      if (!hold) req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom;
      req_wdata = {$urandom, $urandom};
      if (obs_ready) ob_ready_busy = 1'b1;
      if (obs_re && obs_we) ob_overlap = 1'b1;
      if (obs_re) begin
        if (ob_re_cnt == 0) ob_re_first = cyc;
        ob_re_cnt++;
        ob_addr = obs_addr;
      end
      bus_rvalid = obs_re && (ob_re_cnt == dly + 1);
      if (obs_we) begin
        if (ob_we_cnt == 0) ob_we_first = cyc;
        ob_we_cnt++;
        ob_wdata = obs_wdata;
        ob_addr = obs_addr;
      end
      if (obs_resp_valid) begin
        ob_resp_cyc = cyc; ob_rdata = obs_rdata; ob_err = obs_err;
        done = 1'b1; req_valid = 1'b0;
      end
    end
    bus_rvalid = 1'b0;
    req_valid = 1'b0;
    if (!done) ob_timeout = 1'b1;
    @(negedge cpu_clk);
    ob_ready_after = obs_ready;
    ob_resp_after = obs_resp_valid;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rst_ready dut%0d got %b exp 1", s, obs_ready); end
      checks++; if ({obs_resp_valid, obs_err, obs_re, obs_we} !== 4'b0) begin errors++; $display("FAIL rst_strobes dut%0d got %b exp 0000", s, {obs_resp_valid, obs_err, obs_re, obs_we}); end
      checks++; if ({obs_rdata, obs_wdata, obs_addr} !== '0) begin errors++; $display("FAIL rst_data dut%0d got %h/%h/%h exp 0", s, obs_rdata, obs_wdata, obs_addr); end
    end
  endtask

  task automatic test_load_byte();
    sel = 1'b0;
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 64'h0, 64'h80AA_BBCC, 0, 1'b0);
    checks++; if (ob_rdata !== 64'hFFFF_FF80) begin errors++; $display("FAIL lb_signed_rdata got %h exp %h", ob_rdata, 64'hFFFF_FF80); end
    checks++; if (ob_resp_cyc !== 2) begin errors++; $display("FAIL lb_resp_cycle got %0d exp 2", ob_resp_cyc); end
    checks++; if (ob_re_first !== 1 || ob_re_cnt !== 1 || ob_we_cnt !== 0) begin errors++; $display("FAIL lb_strobes got re %0d/%0d we %0d exp 1/1/0", ob_re_first, ob_re_cnt, ob_we_cnt); end
    checks++; if (ob_addr !== 32'h100) begin errors++; $display("FAIL lb_bus_addr got %h exp 100", ob_addr); end
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 64'h0, 64'h80AA_BBCC, 0, 1'b0);
    checks++; if (ob_rdata !== 64'h80) begin errors++; $display("FAIL lbu_rdata got %h exp 80", ob_rdata); end
    checks++; if (ob_resp_cyc !== 2) begin errors++; $display("FAIL lbu_resp_cycle got %0d exp 2", ob_resp_cyc); end
  endtask

  task automatic test_store_half();
    sel = 1'b0;
    run_txn(1'b1, 2'd1, 1'b0, 32'h202, 64'h1234, 64'hDEAD_BEEF, 0, 1'b0);
    checks++; if (ob_addr !== 32'h200) begin errors++; $display("FAIL sh_bus_addr got %h exp 200", ob_addr); end
    checks++; if (ob_re_first !== 1 || ob_we_first !== 2 || ob_we_cnt !== 1) begin errors++; $display("FAIL sh_strobes got re %0d we %0d x%0d exp 1/2 x1", ob_re_first, ob_we_first, ob_we_cnt); end
    checks++; if (ob_wdata !== 64'h1234_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp 1234beef", ob_wdata); end
    checks++; if (ob_resp_cyc !== 3 || ob_rdata !== 64'h0) begin errors++; $display("FAIL sh_resp got cyc %0d rdata %h exp 3/0", ob_resp_cyc, ob_rdata); end
    checks++; if (ob_overlap !== 1'b0) begin errors++; $display("FAIL sh_overlap got %b exp 0", ob_overlap); end
  endtask

  task automatic test_store_dword();
    sel = 1'b1;
    run_txn(1'b1, 2'd3, 1'b0, 32'h08, 64'h0123_4567_89AB_CDEF, {$urandom, $urandom}, 0, 1'b0);
    checks++; if (ob_re_cnt !== 0) begin errors++; $display("FAIL sd_no_read got %0d exp 0", ob_re_cnt); end
    checks++; if (ob_we_first !== 1 || ob_we_cnt !== 1) begin errors++; $display("FAIL sd_we got %0d x%0d exp 1 x1", ob_we_first, ob_we_cnt); end
    checks++; if (ob_wdata !== 64'h0123_4567_89AB_CDEF || ob_addr !== 32'h08) begin errors++; $display("FAIL sd_bus got %h @%h exp 0123456789abcdef @8", ob_wdata, ob_addr); end
    checks++; if (ob_resp_cyc !== 2) begin errors++; $display("FAIL sd_resp_cycle got %0d exp 2", ob_resp_cyc); end
  endtask

  task automatic test_rvalid_delay();
    logic [63:0] mem;
    mem = {32'd0, $urandom};
    sel = 1'b0;
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 64'h0, mem, 3, 1'b1);
    checks++; if (ob_re_first !== 1 || ob_re_cnt !== 4) begin errors++; $display("FAIL dly_re got %0d x%0d exp 1 x4", ob_re_first, ob_re_cnt); end
    checks++; if (ob_resp_cyc !== 5) begin errors++; $display("FAIL dly_resp_cycle got %0d exp 5", ob_resp_cyc); end
    checks++; if (ob_rdata !== mem) begin errors++; $display("FAIL dly_rdata got %h exp %h", ob_rdata, mem); end
    checks++; if (ob_ready_busy !== 1'b0) begin errors++; $display("FAIL dly_ready_busy got %b exp 0", ob_ready_busy); end
    checks++; if (ob_ready_after !== 1'b1 || ob_resp_after !== 1'b0) begin errors++; $display("FAIL dly_after got ready %b resp %b exp 1/0", ob_ready_after, ob_resp_after); end
    @(negedge cpu_clk);
    checks++; if (obs_re !== 1'b0 || obs_ready !== 1'b1) begin errors++; $display("FAIL dly_no_early_accept got re %b ready %b exp 0/1", obs_re, obs_ready); end
  endtask

  task automatic test_reset_mid_op();
    bit saw_we, not_ready;
    sel = 1'b0;
    @(negedge cpu_clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h301;
    req_wdata = 64'h55; bus_rdata = {$urandom, $urandom}; bus_rvalid = 1'b0; req_valid = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    req_valid = 1'b0;
    checks++; if (obs_re !== 1'b1) begin errors++; $display("FAIL rmid_in_rd got re %b exp 1", obs_re); end
    cpu_rst_n = 1'b0;
    #1;
    checks++; if (obs_ready !== 1'b1 || {obs_re, obs_we, obs_resp_valid, obs_err} !== 4'b0) begin errors++; $display("FAIL rmid_ctrl got ready %b strobes %b exp 1/0000", obs_ready, {obs_re, obs_we, obs_resp_valid, obs_err}); end
    checks++; if ({obs_addr, obs_wdata, obs_rdata} !== '0) begin errors++; $display("FAIL rmid_data got %h/%h/%h exp 0", obs_addr, obs_wdata, obs_rdata); end
    saw_we = 1'b0; not_ready = 1'b0;
    repeat (3) begin @(negedge cpu_clk); if (obs_we) saw_we = 1'b1; end
    cpu_rst_n = 1'b1;
    repeat (4) begin
      @(negedge cpu_clk);
      if (obs_we) saw_we = 1'b1;
      if (!obs_ready) not_ready = 1'b1;
    end
    checks++; if (saw_we !== 1'b0 || not_ready !== 1'b0) begin errors++; $display("FAIL rmid_after got we %b notready %b exp 0/0", saw_we, not_ready); end
    sel = 1'b1;
    req_we = 1'b1; req_size = 2'd3; req_addr = 32'h10; req_wdata = {$urandom, $urandom}; req_valid = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    req_valid = 1'b0;
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL rwr_in_wr got we %b exp 1", obs_we); end
    cpu_rst_n = 1'b0;
    #1;
    checks++; if (obs_we !== 1'b0 || obs_wdata !== 64'h0 || obs_ready !== 1'b1) begin errors++; $display("FAIL rwr_abort got we %b wdata %h ready %b exp 0/0/1", obs_we, obs_wdata, obs_ready); end
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
  endtask

  task automatic test_misalign();
    logic [63:0] mem;
    mem = {32'd0, $urandom};
    sel = 1'b0;
    run_txn(1'b0, 2'd2, 1'b0, 32'h102, 64'h0, mem, 0, 1'b0);
`ifdef LSU_MISALIGN_CHK_EN
    checks++; if (ob_resp_cyc !== 1 || ob_err !== 1'b1) begin errors++; $display("FAIL mis_err got cyc %0d err %b exp 1/1", ob_resp_cyc, ob_err); end
    checks++; if (ob_rdata !== 64'h0 || ob_re_cnt !== 0 || ob_we_cnt !== 0) begin errors++; $display("FAIL mis_quiet got rdata %h re %0d we %0d exp 0/0/0", ob_rdata, ob_re_cnt, ob_we_cnt); end
`else
    checks++; if (ob_addr !== 32'h100 || ob_re_cnt !== 1) begin errors++; $display("FAIL mis_trunc_addr got %h re %0d exp 100/1", ob_addr, ob_re_cnt); end
    checks++; if (ob_rdata !== mem || ob_err !== 1'b0 || ob_resp_cyc !== 2) begin errors++; $display("FAIL mis_trunc_load got %h err %b cyc %0d exp %h/0/2", ob_rdata, ob_err, ob_resp_cyc, mem); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      bit          we, uns, mis, full;
      int          sz, es, dw, nb, dly;
      logic [31:0] addr;
      logic [63:0] wd, mem, wmask, exp_rd, exp_wd;
      int          exp_resp, exp_re, exp_we_first;
      sel  = 1'($urandom);
      dw   = sel ? 64 : 32;
      wmask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      we   = 1'($urandom);
      uns  = 1'($urandom);
      sz   = int'($urandom_range(3, 0));
      es   = eff_size(dw, sz);
      nb   = 1 << es;
      addr = $urandom;
      wd   = {$urandom, $urandom};
      mem  = {$urandom, $urandom} & wmask;
      dly  = int'($urandom_range(2, 0));
      full = (nb == dw / 8);
      mis  = (int'(addr) % nb) != 0;
      exp_rd = 64'h0; exp_wd = 64'h0; exp_re = 0; exp_we_first = -1;
`ifdef LSU_MISALIGN_CHK_EN
      if (mis) exp_resp = 1;
      else
`endif
      if (!we) begin
        exp_resp = 2 + dly; exp_re = dly + 1; exp_rd = m_load(dw, es, uns, addr, mem);
      end else if (full) begin
        exp_resp = 2; exp_we_first = 1; exp_wd = wd & wmask;
      end else begin
        exp_resp = 3 + dly; exp_re = dly + 1; exp_we_first = 2 + dly;
        exp_wd = m_merge(dw, es, addr, mem, wd);
      end
      run_txn(we, 2'(sz), uns, addr, wd, mem, dly, 1'b0);
      checks++; if (ob_timeout !== 1'b0 || ob_resp_cyc !== exp_resp) begin errors++; $display("FAIL rnd%0d_resp_cycle got %0d exp %0d", n, ob_resp_cyc, exp_resp); end
      checks++; if (ob_rdata !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h (dw %0d sz %0d addr %h)", n, ob_rdata, exp_rd, dw, sz, addr); end
      checks++; if (ob_err !== (mis && exp_resp == 1)) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", n, ob_err, mis && exp_resp == 1); end
      checks++; if (ob_re_cnt !== exp_re || (exp_re > 0 && ob_re_first !== 1)) begin errors++; $display("FAIL rnd%0d_re got %0d x%0d exp 1 x%0d", n, ob_re_first, ob_re_cnt, exp_re); end
      checks++; if (ob_we_first !== exp_we_first || ob_we_cnt !== (exp_we_first > 0 ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_we got %0d x%0d exp %0d", n, ob_we_first, ob_we_cnt, exp_we_first); end
      if (exp_we_first > 0) begin
        checks++; if (ob_wdata !== exp_wd) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h (dw %0d sz %0d addr %h)", n, ob_wdata, exp_wd, dw, sz, addr); end
      end
      if (exp_re > 0 || exp_we_first > 0) begin
        checks++; if (ob_addr !== (addr & ~32'(dw / 8 - 1))) begin errors++; $display("FAIL rnd%0d_addr got %h exp %h", n, ob_addr, addr & ~32'(dw / 8 - 1)); end
      end
      checks++; if (ob_overlap !== 1'b0 || ob_ready_busy !== 1'b0 || ob_ready_after !== 1'b1 || ob_resp_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_handshake got ovl %b busyrdy %b rdy %b resp %b exp 0/0/1/0", n, ob_overlap, ob_ready_busy, ob_ready_after, ob_resp_after); end
    end
  endtask

  initial begin
    cpu_rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; bus_rdata = '0; bus_rvalid = 1'b0; sel = 1'b0;
    #12;
    test_reset();
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    test_load_byte();
    test_store_half();
    test_store_dword();
    test_rvalid_delay();
    test_reset_mid_op();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
